// File: rtl/btn_gesture_decoder.sv
// Classifies debounced press/long_press activity into click-count and long-press gestures,
// delivered through a single-entry valid/ready event slot with overflow signalling.
module btn_gesture_decoder #(
  parameter int unsigned CLK_FREQUENCY = 100000000,
  parameter int unsigned GAP_MS        = 250,
  parameter int unsigned MAX_CLICKS    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       press,
  input  logic       long_press,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_drop
);

  localparam int unsigned GapClks = CLK_FREQUENCY / 1000 * GAP_MS;
  localparam int unsigned GapW    = $clog2(GapClks + 1);

  localparam logic [GapW-1:0] GapLast      = GapW'(GapClks - 1);
  localparam logic [GapW-1:0] GapOne       = GapW'(1);
  localparam logic [1:0]      MaxClicks    = 2'(MAX_CLICKS);
  localparam logic [2:0]      CodeLongOn   = 3'd4;
  localparam logic [2:0]      CodeLongOff  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StGap,
    StLong
  } state_e;

  state_e            state_q, state_d;
  logic              press_q;
  logic [1:0]        click_cnt_q, click_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              evt_valid_q, evt_valid_d;
  logic [2:0]        evt_code_q, evt_code_d;
  logic              evt_drop_q, evt_drop_d;

  logic              rise;
  logic              fall;
  logic              emit;
  logic [2:0]        emit_code;

  assign rise = press && !press_q;
  assign fall = !press && press_q;

  // Gesture classification
  always_comb begin
    state_d     = state_q;
    click_cnt_d = click_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    emit        = 1'b0;
    emit_code   = 3'd0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          click_cnt_d = 2'd1;
          state_d     = StPressed;
        end
      end

      StPressed: begin
        // A hold turns the whole sequence into a long press; earlier clicks are discarded.
        if (long_press) begin
          emit        = 1'b1;
          emit_code   = CodeLongOn;
          click_cnt_d = 2'd0;
          state_d     = StLong;
        end else if (fall) begin
          if (click_cnt_q == MaxClicks) begin
            emit        = 1'b1;
            emit_code   = {1'b0, click_cnt_q};
            click_cnt_d = 2'd0;
            state_d     = StIdle;
          end else begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end
      end

      StGap: begin
        // A rise on the timeout cycle still extends the sequence.
        if (rise) begin
          click_cnt_d = click_cnt_q + 2'd1;
          state_d     = StPressed;
        end else if (gap_cnt_q == GapLast) begin
          emit        = 1'b1;
          emit_code   = {1'b0, click_cnt_q};
          click_cnt_d = 2'd0;
          gap_cnt_d   = '0;
          state_d     = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapOne;
        end
      end

      StLong: begin
        if (fall) begin
          emit      = 1'b1;
          emit_code = CodeLongOff;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Single-entry event slot: a slot being accepted this cycle can take a new event.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_drop_d  = 1'b0;

    if (emit) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = emit_code;
      end else begin
        evt_drop_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
      evt_code_d  = 3'd0;
    end
  end

  // press_q resets high so a button held through reset does not look like a new press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      press_q     <= 1'b1;
      click_cnt_q <= 2'd0;
      gap_cnt_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 3'd0;
      evt_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_q     <= press;
      click_cnt_q <= click_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_drop  = evt_drop_q;

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed bench for btn_gesture_decoder with GAP_CLKS = 20 and MAX_CLICKS = 3.
module tb_btn_gesture_decoder;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic       press      = 1'b0;
  logic       long_press = 1'b0;
  logic       evt_ready  = 1'b1;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_drop;

  int errors   = 0;
  int checks   = 0;
  int cyc_n    = 0;
  int valid_hi = 0;
  int stab_err = 0;
  int ev_code[$];
  int ev_cyc[$];
  int drop_cyc[$];

  always #5 clk = ~clk;

  btn_gesture_decoder #(
    .CLK_FREQUENCY(10000),
    .GAP_MS       (2),
    .MAX_CLICKS   (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .press     (press),
    .long_press(long_press),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .evt_drop  (evt_drop)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: log handshakes the coming edge will take, then observe 1 ns after it.
  task automatic cyc();
    logic       hold;
    logic [2:0] hcode;
    hold  = evt_valid && !evt_ready;
    hcode = evt_code;
    if (evt_valid && evt_ready) begin
      ev_code.push_back(int'(evt_code));
      ev_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (evt_drop) drop_cyc.push_back(cyc_n);
    if (evt_valid) valid_hi++;
    if (hold && (!evt_valid || evt_code !== hcode)) stab_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Press for n cycles; returns the edge at which the fall is sampled.
  task automatic click(input int n, output int fall);
    press = 1'b1;
    repeat (n) cyc();
    press = 1'b0;
    fall  = cyc_n + 1;
  endtask

  task automatic clr();
    ev_code.delete();
    ev_cyc.delete();
    drop_cyc.delete();
    valid_hi = 0;
    stab_err = 0;
  endtask

  task automatic check_events(input string tag, input int n, input int code0, input int cyc0);
    chk({tag, ".count"}, ev_code.size(), n);
    if (ev_code.size() > 0) begin
      chk({tag, ".code"}, ev_code[0], code0);
      if (cyc0 >= 0) chk({tag, ".cycle"}, ev_cyc[0], cyc0);
    end
  endtask

  initial begin
    int f, f2, l;

    // Reset state
    idle(3);
    chk("rst.valid", int'(evt_valid), 0);
    chk("rst.code", int'(evt_code), 0);
    chk("rst.drop", int'(evt_drop), 0);
    reset_n = 1'b1;
    idle(2);
    chk("rst_rel.valid", int'(evt_valid), 0);

    // Single click
    clr();
    click(5, f);
    idle(30);
    check_events("single", 1, 1, f + 20);
    chk("single.valid_cycles", valid_hi, 1);
    chk("single.drops", drop_cyc.size(), 0);

    // Double click
    clr();
    click(5, f);
    idle(10);
    click(5, f);
    idle(30);
    check_events("double", 1, 2, f + 20);

    // Triple click closes immediately
    clr();
    click(5, f);
    idle(10);
    click(5, f);
    idle(10);
    click(5, f);
    idle(30);
    check_events("triple", 1, 3, f);

    // Long press
    clr();
    press = 1'b1;
    idle(8);
    long_press = 1'b1;
    l = cyc_n + 1;
    idle(30);
    press = 1'b0;
    long_press = 1'b0;
    f = cyc_n + 1;
    idle(5);
    check_events("long", 2, 4, l);
    if (ev_code.size() > 1) begin
      chk("long.end_code", ev_code[1], 5);
      chk("long.end_cycle", ev_cyc[1], f);
    end

    // Click then hold discards the pending click
    clr();
    click(5, f);
    idle(10);
    press = 1'b1;
    idle(8);
    long_press = 1'b1;
    l = cyc_n + 1;
    idle(20);
    press = 1'b0;
    long_press = 1'b0;
    f = cyc_n + 1;
    idle(30);
    check_events("clickhold", 2, 4, l);
    if (ev_code.size() > 1) chk("clickhold.end_code", ev_code[1], 5);

    // Backpressure: pending single click, long start/end dropped
    clr();
    evt_ready = 1'b0;
    click(5, f);
    idle(25);
    chk("bp.pend_valid", int'(evt_valid), 1);
    chk("bp.pend_code", int'(evt_code), 1);
    press = 1'b1;
    idle(8);
    long_press = 1'b1;
    l = cyc_n + 1;
    idle(10);
    press = 1'b0;
    long_press = 1'b0;
    f2 = cyc_n + 1;
    idle(5);
    chk("bp.drop_count", drop_cyc.size(), 2);
    if (drop_cyc.size() > 1) begin
      chk("bp.drop0_cycle", drop_cyc[0], l);
      chk("bp.drop1_cycle", drop_cyc[1], f2);
    end
    chk("bp.hold_code", int'(evt_code), 1);
    chk("bp.stable", stab_err, 0);
    chk("bp.no_accept", ev_code.size(), 0);
    evt_ready = 1'b1;
    idle(3);
    check_events("bp.deliver", 1, 1, -1);
    chk("bp.after_valid", int'(evt_valid), 0);
    chk("bp.after_code", int'(evt_code), 0);

    // Press held across reset deassertion
    clr();
    press = 1'b1;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(10);
    press = 1'b0;
    idle(30);
    chk("held_rst.count", ev_code.size(), 0);
    click(5, f);
    idle(30);
    check_events("held_rst.single", 1, 1, f + 20);

    // Rise exactly on the timeout cycle continues the sequence
    clr();
    click(5, f);
    idle(20);
    click(5, f);
    idle(30);
    check_events("edge_gap", 1, 2, f + 20);

    // One cycle later the first sequence has already closed
    clr();
    click(5, f);
    idle(21);
    click(5, f2);
    idle(30);
    check_events("late_gap", 2, 1, f + 20);
    if (ev_code.size() > 1) begin
      chk("late_gap.code2", ev_code[1], 1);
      chk("late_gap.cycle2", ev_cyc[1], f2 + 20);
    end

    // Reset while in the gap abandons the sequence
    clr();
    click(5, f);
    idle(5);
    reset_n = 1'b0;
    idle(1);
    chk("gap_rst.valid", int'(evt_valid), 0);
    chk("gap_rst.code", int'(evt_code), 0);
    chk("gap_rst.drop", int'(evt_drop), 0);
    reset_n = 1'b1;
    idle(30);
    chk("gap_rst.count", ev_code.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
